// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Holds the FSM state enum, grant-owner encoding and default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// master: arbiter view (serves fetch/data, drives memory); slave: environment view.
interface unified_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // fetch port
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ready_o;
    logic [DATA_W-1:0] if_rdata_o;
    // data port
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_ready_o;
    logic [DATA_W-1:0] dm_rdata_o;
    // memory side
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    // pipeline control
    logic              stall_o;
    logic              err_o;

    modport master (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_ack_i, mem_rdata_i,
        output if_ready_o, if_rdata_o,
        output dm_ready_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o, err_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_ack_i, mem_rdata_i,
        input  if_ready_o, if_rdata_o,
        input  dm_ready_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o, err_o
    );

endinterface

// File: rtl/unified_mem_arbiter_watchdog.sv
// Loadable up-counter with clear/enable and a terminal-count flag.
// Ports: clk_i, rst_i, clr_i, en_i, load_i, load_val_i[W], tc_o (count==TC).
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int W  = 7,
    parameter int TC = 63
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    localparam logic [W-1:0] TC_V = W'(TC);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // clear beats load beats count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_V);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Ports: clk_i, rst_i (async, active-high), bus (fetch/data/memory/stall/err).
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_DWIN = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    unified_mem_arbiter_if.master bus
);

    localparam int DW_W = $clog2(MAX_DWIN + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [DW_W-1:0] DWIN_MAX = DW_W'(MAX_DWIN);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [DW_W-1:0]   dwin_q, dwin_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              err_q, err_d;

    logic gnt_d;
    logic gnt_i;
    logic wd_clr;
    logic wd_en;
    logic wd_tc;

    // data wins unless fetch has waited through MAX_DWIN data grants
    assign gnt_d = bus.dm_req_i & ~(bus.if_req_i & (dwin_q == DWIN_MAX));
    assign gnt_i = ~gnt_d & bus.if_req_i;

    arb_watchdog #(
        .W  (WD_W),
        .TC (TIMEOUT - 1)
    ) u_wd (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (wd_clr),
        .en_i       (wd_en),
        .load_i     (1'b0),
        .load_val_i ({WD_W{1'b0}}),
        .tc_o       (wd_tc)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        dwin_d      = dwin_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        err_d       = err_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_d) begin
                    owner_d     = OWN_D;
                    mem_we_d    = bus.dm_we_i;
                    mem_addr_d  = bus.dm_addr_i;
                    mem_wdata_d = bus.dm_wdata_i;
                    // saturating count of data grants taken while fetch waits
                    if (!bus.if_req_i) begin
                        dwin_d = '0;
                    end else if (dwin_q != DWIN_MAX) begin
                        dwin_d = dwin_q + 1'b1;
                    end
                end else if (gnt_i) begin
                    owner_d     = OWN_I;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr_i;
                    mem_wdata_d = '0;
                    dwin_d      = '0;
                end
                if (gnt_d || gnt_i) begin
                    mem_req_d = 1'b1;
                    wd_clr    = 1'b1;
                    state_d   = BUSY;
                end
            end

            BUSY: begin
                if (bus.mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        if (owner_q == OWN_D) begin
                            dm_rdata_d = bus.mem_rdata_i;
                        end else begin
                            if_rdata_d = bus.mem_rdata_i;
                        end
                    end
                    if_ready_d = (owner_q == OWN_I);
                    dm_ready_d = (owner_q == OWN_D);
                    state_d    = RESP;
                end else if (wd_tc) begin
                    // hung access: complete with zero data and flag it
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_D) begin
                        dm_rdata_d = '0;
                    end else begin
                        if_rdata_d = '0;
                    end
                    if_ready_d = (owner_q == OWN_I);
                    dm_ready_d = (owner_q == OWN_D);
                    err_d      = 1'b1;
                    state_d    = RESP;
                end else begin
                    wd_en = 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            dwin_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            dwin_q      <= dwin_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_ready_o  = if_ready_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_ready_o  = dm_ready_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.err_o       = err_q;

    // releases in the ready cycle so each stage advances exactly once
    assign bus.stall_o = (bus.if_req_i & ~if_ready_q)
                       | (bus.dm_req_i & ~dm_ready_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a transaction-level model.
// Model tracks one outstanding access, its ready cycle and expected data.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXD = 4;
    localparam int TO   = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    unified_mem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_DWIN (MAXD),
        .TIMEOUT  (TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // requester state
    bit          if_pend, if_gnt, dm_pend, dm_gnt, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    bit          drv_if, drv_dm;

    // outstanding access in the model
    bit          act, a_own, a_we, a_to;
    logic [31:0] a_addr, a_wdata, a_rdat;
    int          a_g, a_k, a_rdy;

    int          dwin;
    logic [31:0] e_if_rd, e_dm_rd;
    bit          e_err;

    int p_if, p_dm, p_drop, k_min, k_max;
    bit k_never;
    int late_ack;
    int last_g, last_if_rdy;

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.dm_req_i    = 1'b0;
        bus.dm_we_i     = 1'b0;
        bus.dm_addr_i   = '0;
        bus.dm_wdata_i  = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
    endtask

    task automatic model_reset();
        act      = 1'b0;
        dwin     = 0;
        e_if_rd  = '0;
        e_dm_rd  = '0;
        e_err    = 1'b0;
        if_pend  = 1'b0;
        if_gnt   = 1'b0;
        dm_pend  = 1'b0;
        dm_gnt   = 1'b0;
        late_ack = -1;
    endtask

    task automatic step();
        bit ack, exp_mreq, exp_ir, exp_dr, idle_now, gi, gd;
        @(posedge clk);
        #1;
        cyc++;
        if (!if_pend && int'($urandom_range(99)) < p_if) begin
            if_pend = 1'b1;
            if_gnt  = 1'b0;
            if_addr = 32'h1000 + 32'($urandom_range(63)) * 4;
        end
        if (!dm_pend && int'($urandom_range(99)) < p_dm) begin
            dm_pend  = 1'b1;
            dm_gnt   = 1'b0;
            dm_we    = 1'($urandom_range(1));
            dm_addr  = 32'h2000 + 32'($urandom_range(63)) * 4;
            dm_wdata = $urandom;
        end
        if (if_pend && !if_gnt && int'($urandom_range(99)) < p_drop)
            if_pend = 1'b0;
        if (dm_pend && !dm_gnt && int'($urandom_range(99)) < p_drop)
            dm_pend = 1'b0;
        drv_if = if_pend;
        drv_dm = dm_pend;
        // after a grant the requester inputs wander; the DUT must ignore them
        bus.if_req_i   = drv_if;
        bus.if_addr_i  = if_gnt ? $urandom : if_addr;
        bus.dm_req_i   = drv_dm;
        bus.dm_we_i    = dm_gnt ? 1'($urandom_range(1)) : dm_we;
        bus.dm_addr_i  = dm_gnt ? $urandom : dm_addr;
        bus.dm_wdata_i = dm_gnt ? $urandom : dm_wdata;
        ack = (act && !a_to && cyc == a_g + 1 + a_k) || (cyc == late_ack);
        bus.mem_ack_i = ack;
        if (act && !a_to && cyc == a_g + 1 + a_k) begin
            a_rdat = mrd(a_addr);
            if (a_we) mem[a_addr] = a_wdata;
            bus.mem_rdata_i = a_rdat;
        end else begin
            bus.mem_rdata_i = $urandom;
        end
        #1;
        exp_mreq = act && cyc > a_g && cyc < a_rdy;
        exp_ir   = act && cyc == a_rdy && !a_own;
        exp_dr   = act && cyc == a_rdy && a_own;
        if (exp_ir) e_if_rd = a_to ? 32'h0 : a_rdat;
        if (exp_dr && (a_to || !a_we)) e_dm_rd = a_to ? 32'h0 : a_rdat;
        if (act && cyc == a_rdy && a_to) e_err = 1'b1;
        if (bus.if_ready_o) last_if_rdy = cyc;
        chk("mem_req", 32'(bus.mem_req_o), 32'(exp_mreq));
        if (exp_mreq) begin
            chk("mem_addr", bus.mem_addr_o, a_addr);
            chk("mem_we", 32'(bus.mem_we_o), 32'(a_we));
            if (a_we) chk("mem_wdata", bus.mem_wdata_o, a_wdata);
        end
        chk("if_ready", 32'(bus.if_ready_o), 32'(exp_ir));
        chk("dm_ready", 32'(bus.dm_ready_o), 32'(exp_dr));
        chk("if_rdata", bus.if_rdata_o, e_if_rd);
        chk("dm_rdata", bus.dm_rdata_o, e_dm_rd);
        chk("err", 32'(bus.err_o), 32'(e_err));
        chk("stall", 32'(bus.stall_o),
            32'((drv_if && !exp_ir) || (drv_dm && !exp_dr)));
        idle_now = !act;
        if (act && cyc == a_rdy) begin
            act = 1'b0;
            if (a_own) begin
                dm_pend = 1'b0;
                dm_gnt  = 1'b0;
            end else begin
                if_pend = 1'b0;
                if_gnt  = 1'b0;
            end
        end
        if (idle_now) begin
            gd = drv_dm && !(drv_if && dwin == MAXD);
            gi = !gd && drv_if;
            if (gd) dwin = drv_if ? ((dwin < MAXD) ? dwin + 1 : dwin) : 0;
            else if (gi) dwin = 0;
            if (gd || gi) begin
                act     = 1'b1;
                a_own   = gd;
                a_g     = cyc;
                last_g  = cyc;
                a_addr  = gd ? dm_addr : if_addr;
                a_we    = gd && dm_we;
                a_wdata = dm_wdata;
                if (gd) dm_gnt = 1'b1;
                else    if_gnt = 1'b1;
                if (k_never) begin
                    a_to     = 1'b1;
                    a_k      = TO;
                    a_rdy    = cyc + TO + 1;
                    late_ack = a_rdy;
                end else begin
                    a_to  = 1'b0;
                    a_k   = int'($urandom_range(k_max, k_min));
                    a_rdy = cyc + 2 + a_k;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        p_if = 0; p_dm = 0; p_drop = 0;
        k_min = 0; k_max = 3; k_never = 1'b0;
        last_g = 0; last_if_rdy = -1000;
        #3;
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_if_ready", 32'(bus.if_ready_o), 32'h0);
        chk("rst_dm_ready", 32'(bus.dm_ready_o), 32'h0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
        chk("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
        chk("rst_err", 32'(bus.err_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single fetch at 0x40, three wait cycles
        mem[32'h40] = 32'h8C01_0004;
        k_min = 3; k_max = 3;
        if_pend = 1'b1; if_gnt = 1'b0; if_addr = 32'h40;
        run(8);
        chk("fetch_lat", 32'(last_if_rdy - last_g), 32'd5);
        chk("fetch_data", bus.if_rdata_o, 32'h8C01_0004);

        // simultaneous fetch and data write
        k_min = 0; k_max = 2;
        if_pend = 1'b1; if_gnt = 1'b0; if_addr = 32'h80;
        dm_pend = 1'b1; dm_gnt = 1'b0; dm_we = 1'b1;
        dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        run(14);
        chk("dm_write_mem", mem[32'h100], 32'hDEAD_BEEF);

        // both ports saturated: starvation limit forces fetches through
        p_if = 100; p_dm = 100;
        run(60);
        p_if = 0; p_dm = 0;
        run(12);

        // random mix with drops
        p_if = 40; p_dm = 40; p_drop = 5; k_min = 0; k_max = 6;
        run(3000);
        p_if = 0; p_dm = 0; p_drop = 0;
        run(20);

        // memory never answers: watchdog completes the read with zero
        k_never = 1'b1;
        dm_pend = 1'b1; dm_gnt = 1'b0; dm_we = 1'b0; dm_addr = 32'h2100;
        run(TO + 6);
        k_never = 1'b0;
        late_ack = -1;
        chk("err_sticky", 32'(bus.err_o), 32'h1);
        chk("to_rdata", bus.dm_rdata_o, 32'h0);

        // reset in the middle of a long access
        k_min = 20; k_max = 20;
        if_pend = 1'b1; if_gnt = 1'b0; if_addr = 32'h1234;
        run(4);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("midrst_if_ready", 32'(bus.if_ready_o), 32'h0);
        chk("midrst_dm_ready", 32'(bus.dm_ready_o), 32'h0);
        chk("midrst_err", 32'(bus.err_o), 32'h0);
        drive_idle();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        k_min = 1; k_max = 1;
        mem[32'h1300] = 32'hA5A5_0001;
        if_pend = 1'b1; if_gnt = 1'b0; if_addr = 32'h1300;
        run(6);
        chk("post_rst_lat", 32'(last_if_rdy - last_g), 32'd3);
        chk("post_rst_data", bus.if_rdata_o, 32'hA5A5_0001);

        // data read leaves fetch data alone
        k_min = 2; k_max = 2;
        mem[32'h2200] = 32'h1234_5678;
        dm_pend = 1'b1; dm_gnt = 1'b0; dm_we = 1'b0; dm_addr = 32'h2200;
        run(7);
        chk("dm_read", bus.dm_rdata_o, 32'h1234_5678);
        chk("if_rd_kept", bus.if_rdata_o, 32'hA5A5_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
